// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion: one key_gen round reused for all ten
// rounds, with the eleven round keys kept in a registered-read file.
module key_schedule_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q [NR+1];
  logic [127:0] rk_d [NR+1];
  logic [127:0] w_q, w_d;
  logic [127:0] nk;
  logic [127:0] rd_q, rd_d;
  logic [7:0]   rc_q, rc_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         kv_q, kv_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60;
    logic [7:0] x120, x240, x252, v;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    v    = gmul(x252, x2);
    return v
      ^ {v[6:0], v[7]}
      ^ {v[5:0], v[7:6]}
      ^ {v[4:0], v[7:5]}
      ^ {v[3:0], v[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_gen(
    input logic [127:0] w,
    input logic [31:0]  rcon
  );
    logic [31:0] w0, w1, w2, w3, t;
    logic [31:0] n0, n1, n2, n3;
    w0 = w[127:96];
    w1 = w[95:64];
    w2 = w[63:32];
    w3 = w[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]),   sbox(w3[31:24])};
    t  = t ^ rcon;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    w_d     = w_q;
    rc_d    = rc_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    nk      = key_gen(w_q, {rc_q, 24'h0});
    rd_d    = (rk_addr <= 4'(NR)) ? rk_q[rk_addr] : '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rk_d[0] = key_in;
          w_d     = key_in;
          rc_d    = 8'h01;
          round_d = 4'd1;
          kv_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[round_q] = nk;
        w_d           = nk;
        rc_d          = xtime(rc_q);
        round_d       = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      w_q     <= '0;
      rd_q    <= '0;
      rc_q    <= 8'h01;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      w_q     <= w_d;
      rd_q    <= rd_d;
      rc_q    <= rc_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = kv_q;
  assign rk_data   = rd_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench: stimulus predicts status and read data per cycle,
// a monitor compares them after every rising edge.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, done, key_valid;
  logic [3:0]   rk_addr = '0;
  logic [127:0] rk_data;

  key_schedule_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy;
    logic done;
    logic kv;
  } st_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

  logic [7:0]   sb [256];
  logic [127:0] mem [11];
  logic [127:0] sched [11];
  bit           m_busy;
  bit           m_kv;
  int           m_round;

  st_t          st_q [$];
  logic [127:0] rd_q [$];
  int           ad_q [$];

  int checks = 0;
  int errors = 0;

  // S-box table built from the multiplicative-group walk (p *= 3, q /= 3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ RCON[i/4-1];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(
    input logic         s,
    input logic [127:0] k,
    input logic [3:0]   a,
    input logic         r,
    input logic         lit_en,
    input logic [127:0] lit
  );
    st_t e;
    @(negedge clk);
    start   = s;
    key_in  = k;
    rk_addr = a;
    rst     = r;
    if (r)           rd_q.push_back('0);
    else if (lit_en) rd_q.push_back(lit);
    else             rd_q.push_back(a <= 4'd10 ? mem[a] : '0);
    ad_q.push_back(int'(a));
    e.done = 1'b0;
    if (r) begin
      m_busy = 0;
      m_kv   = 0;
      for (int i = 0; i < 11; i++) mem[i] = '0;
    end else if (!m_busy) begin
      if (s) begin
        expand(k);
        mem[0]  = k;
        m_busy  = 1;
        m_kv    = 0;
        m_round = 1;
      end
    end else begin
      mem[m_round] = sched[m_round];
      if (m_round == 10) begin
        m_busy = 0;
        m_kv   = 1;
        e.done = 1'b1;
      end
      m_round++;
    end
    e.busy = m_busy;
    e.kv   = m_kv;
    st_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input logic [3:0] a);
    drive(1'b0, rnd128(), a, 1'b0, 1'b0, '0);
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) idle(4'(a));
  endtask

  // amode: 0 random address, 1 previous round, 2 round being written
  task automatic run(
    input logic [127:0] k,
    input int           amode,
    input int           stray_at
  );
    logic [3:0] a;
    drive(1'b1, k, 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
    for (int kk = 1; kk <= 10; kk++) begin
      if (amode == 1)      a = 4'(kk - 1);
      else if (amode == 2) a = 4'(kk);
      else                 a = 4'($urandom_range(0, 15));
      drive(kk == stray_at, rnd128(), a, 1'b0, 1'b0, '0);
    end
  endtask

  always @(posedge clk) begin
    st_t          e;
    logic [127:0] x;
    int           a;
    #1;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      checks += 3;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL busy: got %b expected %b", busy, e.busy);
      end
      if (done !== e.done) begin
        errors++;
        $display("FAIL done: got %b expected %b", done, e.done);
      end
      if (key_valid !== e.kv) begin
        errors++;
        $display("FAIL key_valid: got %b expected %b", key_valid, e.kv);
      end
    end
    if (rd_q.size() > 0) begin
      x = rd_q.pop_front();
      a = ad_q.pop_front();
      checks++;
      if (rk_data !== x) begin
        errors++;
        $display("FAIL rk_data[%0d]: got %h expected %h", a, rk_data, x);
      end
    end
  end

  initial begin
    build_sbox();
    for (int i = 0; i < 11; i++) mem[i] = '0;
    m_busy = 0;
    m_kv   = 0;
    m_round = 0;

    for (int i = 0; i < 3; i++)
      drive(1'b0, '0, 4'(i), 1'b1, 1'b0, '0);
    sweep();

    run(FIPS_KEY, 0, 0);
    sweep();
    drive(1'b0, '0, 4'd0, 1'b0, 1'b1, FIPS_KEY);
    drive(1'b0, '0, 4'd1, 1'b0, 1'b1, FIPS_RK1);
    drive(1'b0, '0, 4'd10, 1'b0, 1'b1, FIPS_RK10);

    run('0, 1, 0);
    idle(4'd10);
    drive(1'b0, '1, 4'd1, 1'b0, 1'b1, ZERO_RK1);

    // A second start at E5 must be ignored.
    run(rnd128(), 0, 5);
    idle(4'd0);
    sweep();

    // Reset asserted at E4 of an expansion.
    drive(1'b1, rnd128(), 4'd3, 1'b0, 1'b0, '0);
    for (int kk = 1; kk <= 3; kk++) idle(4'(kk));
    drive(1'b0, rnd128(), 4'd2, 1'b1, 1'b0, '0);
    idle(4'd0);
    sweep();
    run(rnd128(), 0, 0);
    sweep();

    // Back-to-back: second start lands in the done cycle.
    run(rnd128(), 0, 0);
    run(rnd128(), 2, 0);
    sweep();

    for (int n = 0; n < 3; n++) begin
      run(rnd128(), $urandom_range(0, 2), $urandom_range(0, 10));
      for (int j = 0; j < 4; j++) idle(4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    @(negedge clk);
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d status and %0d reads unchecked",
               st_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
